// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, buffers responses.
// Define FETCH_MISALIGN_TRAP_EN for the misaligned-redirect FAULT state and fetch_fault.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          CNT_W      = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [1:0]  FAULT = 2'd3;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`endif

    logic [1:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [31:0]      data_mem [FIFO_DEPTH];
    logic [31:0]      pc_mem   [FIFO_DEPTH];

    logic             acc;
    logic             rsp_ok;
    logic             push;
    logic             pop;
    logic             drain_pend;
    logic [31:0]      tgt;
    logic [CNT_W:0]   credit;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic             misal;
    logic             pend_q, pend_d;
    logic [31:0]      fault_pc_q, fault_pc_d;

    assign tgt        = redirect_pc;
    assign misal      = |redirect_pc[1:0];
    assign drain_pend = pend_q;
`else
    assign tgt        = redirect_pc & 32'hFFFF_FFFC;
    assign drain_pend = 1'b0;
`endif

    // A slot is reserved for every outstanding request, so pushes never overflow.
    assign credit         = {1'b0, out_q} + {1'b0, cnt_q};
    assign imem_req_valid = (state_q == FETCH) && !redirect_valid
                          && (credit < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign acc            = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && (out_q != '0);
    assign pop            = (cnt_q != '0) && inst_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        push       = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        pend_d     = pend_q;
        fault_pc_d = fault_pc_q;
`endif
        if (acc) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            out_d      = out_q + CNT_W'(1);
        end
        if (rsp_ok) begin
            out_d = out_d - CNT_W'(1);
        end
        if (redirect_valid) begin
            fetch_pc_d = tgt;
            rsp_pc_d   = tgt;
            drop_d     = out_d;
            cnt_d      = '0;
            rd_d       = '0;
            wr_d       = '0;
            state_d    = (out_d != '0) ? DRAIN : FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
            pend_d     = misal;
            fault_pc_d = redirect_pc;
            if (misal && (out_d == '0)) begin
                state_d = FAULT;
            end
`endif
        end else begin
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            push = rsp_ok && (drop_q == '0);
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_d     = wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
            case (state_q)
                IDLE: state_d = FETCH;
                DRAIN: begin
                    if (drop_d == '0) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        state_d = drain_pend ? FAULT : FETCH;
`else
                        state_d = drain_pend ? IDLE : FETCH;
`endif
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        inst_valid = (cnt_q != '0);
        inst       = inst_valid ? data_mem[rd_q] : '0;
        inst_pc    = inst_valid ? pc_mem[rd_q] : '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_fault = (state_q == FAULT);
        if (fetch_fault) begin
            inst_valid = 1'b1;
            inst       = NOP;
            inst_pc    = fault_pc_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_q] <= imem_rsp_data;
            pc_mem[wr_q]   <= rsp_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            pend_q     <= 1'b0;
            fault_pc_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            pend_q     <= pend_d;
            fault_pc_q <= fault_pc_d;
`endif
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed phases, queue-based monitors.
// A small in-order memory model answers accepted requests.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;
    int req_hs = 0;
    int cyc = 0;
    bit rsp_en = 1'b0;

    logic [31:0] exp_req[$];
    logic [63:0] exp_inst[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    inst_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .FIFO_DEPTH(2),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault(fault)
`endif
    );

`ifndef FETCH_MISALIGN_TRAP_EN
    assign fault = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return 32'hA5C3_0000 ^ a;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_req.push_back(base + 32'(4 * i));
    endtask

    task automatic push_inst(input logic [31:0] base, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            exp_inst.push_back({a, memfn(a)});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise ready until n more requests are accepted, bounded.
    task automatic grant(input int n);
        int tgt;
        tgt = req_hs + n;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 40 && req_hs < tgt; i++) begin
            @(posedge clk);
            #1;
        end
        imem_req_ready = 1'b0;
        if (req_hs < tgt) begin
            n_checks++;
            n_errors++;
            $display("FAIL grant_timeout: got %0d handshakes, expected %0d",
                     req_hs, tgt);
        end
    endtask

    // Request monitor and memory-model bookkeeping.
    always @(negedge clk) begin
        if (rst && imem_req_valid && imem_req_ready) begin
            req_hs++;
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + 1);
            n_checks++;
            if (exp_req.size() == 0) begin
                n_errors++;
                $display("FAIL req_unexpected: got addr %0h, expected none",
                         imem_req_addr);
            end else begin
                n_checks--;
                chk("req_addr", imem_req_addr, exp_req.pop_front());
            end
        end
    end

    // Decode-side monitor.
    always @(negedge clk) begin
        if (rst && inst_valid && inst_ready && !fault) begin
            n_checks++;
            if (exp_inst.size() == 0) begin
                n_errors++;
                $display("FAIL inst_unexpected: got pc %0h data %0h, expected none",
                         inst_pc, inst);
            end else begin
                n_checks--;
                chk("inst_pc_data", {inst_pc, inst}, exp_inst.pop_front());
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (rsp_en && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_fault", fault, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Streaming from reset
        rsp_en = 1'b1;
        inst_ready = 1'b1;
        push_req(32'h0, 6);
        push_inst(32'h0, 6);
        grant(6);
        idle(6);

        // Backpressure: FIFO fills, fetch stalls, resumes after one pop
        inst_ready = 1'b0;
        push_req(32'h18, 2);
        imem_req_ready = 1'b1;
        idle(6);
        @(negedge clk);
        chk("full_no_req", imem_req_valid, 0);
        chk("full_head_valid", inst_valid, 1);
        chk("full_head_pc", inst_pc, 32'h18);
        chk("full_head_data", inst, 32'hA5C3_0018);
        push_inst(32'h18, 1);
        push_req(32'h20, 1);
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("pop_cycle_no_req", imem_req_valid, 0);
        @(posedge clk);
        #1;
        inst_ready = 1'b0;
        @(negedge clk);
        chk("resume_valid", imem_req_valid, 1);
        chk("resume_addr", imem_req_addr, 32'h20);
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        push_inst(32'h1C, 2);
        inst_ready = 1'b1;
        idle(6);

        // Redirect with two requests in flight
        @(negedge clk);
        rsp_en = 1'b0;
        @(posedge clk);
        #1;
        push_req(32'h24, 2);
        grant(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        chk("redir_no_req", imem_req_valid, 0);
        rsp_en = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("drain1_no_req", imem_req_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drain2_no_req", imem_req_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drain_exit_valid", imem_req_valid, 1);
        chk("drain_exit_addr", imem_req_addr, 32'h100);
        @(posedge clk);
        #1;
        push_req(32'h100, 2);
        push_inst(32'h100, 2);
        grant(2);
        idle(6);

        // Redirect coinciding with a pop and an arriving response
        inst_ready = 1'b0;
        @(negedge clk);
        rsp_en = 1'b0;
        @(posedge clk);
        #1;
        push_req(32'h108, 2);
        grant(2);
        push_inst(32'h108, 1);
        @(negedge clk);
        rsp_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        chk("rp_no_req", imem_req_valid, 0);
        chk("rp_head_valid", inst_valid, 1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rp_flushed", inst_valid, 0);
        chk("rp_req_valid", imem_req_valid, 1);
        chk("rp_req_addr", imem_req_addr, 32'h200);
        @(posedge clk);
        #1;
        push_req(32'h200, 1);
        push_inst(32'h200, 1);
        grant(1);
        idle(6);

        // Memory stalled, redirect while the request is pending
        for (int i = 1; i <= 5; i++) begin
            redirect_valid = (i == 3);
            redirect_pc = 32'h40;
            @(negedge clk);
            if (i < 3) begin
                chk("stall_old_valid", imem_req_valid, 1);
                chk("stall_old_addr", imem_req_addr, 32'h204);
            end else if (i == 3) begin
                chk("stall_redir_no_req", imem_req_valid, 0);
            end else begin
                chk("stall_new_valid", imem_req_valid, 1);
                chk("stall_new_addr", imem_req_addr, 32'h40);
            end
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b0;
        push_req(32'h40, 1);
        push_inst(32'h40, 1);
        grant(1);
        idle(6);

        // Reset with responses still in flight
        inst_ready = 1'b0;
        @(negedge clk);
        rsp_en = 1'b0;
        @(posedge clk);
        #1;
        push_req(32'h44, 2);
        grant(2);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_valid", imem_req_valid, 0);
        chk("mid_rst_addr", imem_req_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        rsp_en = 1'b1;
        @(posedge clk);
        #1;
        idle(4);
        @(negedge clk);
        chk("stale_ignored", inst_valid, 0);
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        push_req(32'h0, 1);
        push_inst(32'h0, 1);
        grant(1);
        idle(6);

`ifdef FETCH_MISALIGN_TRAP_EN
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("fault_flag", fault, 1);
        chk("fault_valid", inst_valid, 1);
        chk("fault_inst", inst, 32'h13);
        chk("fault_pc", inst_pc, 32'h102);
        chk("fault_no_req", imem_req_valid, 0);
        @(posedge clk);
        #1;
        idle(3);
        @(negedge clk);
        chk("fault_hold", fault, 1);
        chk("fault_hold_pc", inst_pc, 32'h102);
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("fault_clear", fault, 0);
        chk("fault_exit_valid", imem_req_valid, 1);
        chk("fault_exit_addr", imem_req_addr, 32'h200);
        @(posedge clk);
        #1;
        push_req(32'h200, 1);
        push_inst(32'h200, 1);
        grant(1);
        idle(6);
`else
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("align_valid", imem_req_valid, 1);
        chk("align_addr", imem_req_addr, 32'h100);
        @(posedge clk);
        #1;
        push_req(32'h100, 1);
        push_inst(32'h100, 1);
        grant(1);
        idle(6);
`endif

        idle(4);
        chk("req_queue_empty", exp_req.size(), 0);
        chk("inst_queue_empty", exp_inst.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
